// File: rtl/cv32e40p_rf_ctx_engine.sv
// Register-file context engine: streams x1..LAST out of the regfile (save)
// or streams words back into x1..LAST (restore), with abort and done pulse.
module cv32e40p_rf_ctx_engine #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          FPU        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  dir_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i
);

  // One extra index bit so stepping past register 63 cannot wrap to 0
  localparam int unsigned IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] LAST    = FPU ? IW'(63) : IW'(31);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_ONE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rf_raddr_o  = '0;
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    in_ready_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idx_d = IDX_ONE;
        if (start_i) begin
          state_d = dir_i ? S_RESTORE : S_SAVE;
        end
      end

      S_SAVE: begin
        if (idx_q <= LAST) begin
          rf_raddr_o = ADDR_WIDTH'(idx_q);
        end
        if (abort_i) begin
          state_d     = S_IDLE;
          idx_d       = IDX_ONE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end else if ((idx_q <= LAST) && (!out_valid_q || out_ready_i)) begin
          out_valid_d = 1'b1;
          out_data_d  = rf_rdata_i;
          idx_d       = IW'(idx_q + IDX_ONE);
        end else if ((idx_q > LAST) && out_valid_q && out_ready_i) begin
          // Last word accepted: drain the entry and finish
          state_d     = S_DONE;
          idx_d       = IDX_ONE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end

      S_RESTORE: begin
        in_ready_o = 1'b1;
        rf_we_o    = in_valid_i;
        rf_waddr_o = ADDR_WIDTH'(idx_q);
        rf_wdata_o = in_data_i;
        if (abort_i) begin
          state_d = S_IDLE;
          idx_d   = IDX_ONE;
        end else if (in_valid_i) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
            idx_d   = IDX_ONE;
          end else begin
            idx_d = IW'(idx_q + IDX_ONE);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = IDX_ONE;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = IDX_ONE;
      end
    endcase
  end

  assign busy_o      = (state_q == S_SAVE) || (state_q == S_RESTORE);
  assign done_o      = (state_q == S_DONE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_cv32e40p_rf_ctx_engine.sv
// Bench for cv32e40p_rf_ctx_engine: one instance without FP bank, one with;
// expected stream/write traffic is queued at stimulus time and popped by a monitor.
module tb_cv32e40p_rf_ctx_engine;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, dir, abort, out_ready, in_valid;
  logic [DW-1:0] in_data;
  logic          sel;

  logic          busy0, done0, we0, ov0, ir0;
  logic [AW-1:0] raddr0, waddr0;
  logic [DW-1:0] rdata0, wdata0, od0;
  logic          busy1, done1, we1, ov1, ir1;
  logic [AW-1:0] raddr1, waddr1;
  logic [DW-1:0] rdata1, wdata1, od1;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
    return (a == '0) ? '0 : DW'(32'h1000 + 32'(a));
  endfunction

  assign rdata0 = rf_val(raddr0);
  assign rdata1 = rf_val(raddr1);

  cv32e40p_rf_ctx_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start & ~sel), .dir_i(dir), .abort_i(abort),
    .busy_o(busy0), .done_o(done0), .rf_raddr_o(raddr0), .rf_rdata_i(rdata0),
    .rf_we_o(we0), .rf_waddr_o(waddr0), .rf_wdata_o(wdata0),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0),
    .in_valid_i(in_valid), .in_ready_o(ir0), .in_data_i(in_data));

  cv32e40p_rf_ctx_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start & sel), .dir_i(dir), .abort_i(abort),
    .busy_o(busy1), .done_o(done1), .rf_raddr_o(raddr1), .rf_rdata_i(rdata1),
    .rf_we_o(we1), .rf_waddr_o(waddr1), .rf_wdata_o(wdata1),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
    .in_valid_i(in_valid), .in_ready_o(ir1), .in_data_i(in_data));

  logic          busy, done, rf_we, ov, in_ready;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, od;
  assign busy     = sel ? busy1  : busy0;
  assign done     = sel ? done1  : done0;
  assign rf_we    = sel ? we1    : we0;
  assign ov       = sel ? ov1    : ov0;
  assign in_ready = sel ? ir1    : ir0;
  assign waddr    = sel ? waddr1 : waddr0;
  assign wdata    = sel ? wdata1 : wdata0;
  assign od       = sel ? od1    : od0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0]    sv_q[$];
  logic [AW+DW-1:0] rs_q[$];
  int               cyc = 0;
  int               hs_cnt, first_hs, last_hs, done_cnt;
  logic             stall_prev;
  logic [DW-1:0]    stall_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboards on every accepted save word / regfile write
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) chk("stall_hold", {ov, od}, {1'b1, stall_data});
      stall_prev = ov && !out_ready;
      stall_data = od;
      if (ov && out_ready) begin
        if (sv_q.size() == 0) chk("save_extra", 64'(sv_q.size()), 64'd1);
        else chk("save_word", od, sv_q.pop_front());
        hs_cnt++;
        if (hs_cnt == 1) first_hs = cyc;
        last_hs = cyc;
      end
      if (rf_we) begin
        chk("waddr_nz", 64'(waddr != '0), 64'd1);
        if (rs_q.size() == 0) chk("write_extra", 64'(rs_q.size()), 64'd1);
        else chk("restore_wr", {waddr, wdata}, rs_q.pop_front());
      end
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic pulse_start(input logic d);
    dir   = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cyc);
    int n;
    n = 0;
    while (done_cnt == base && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == base) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_save(input int last);
    for (int i = 1; i <= last; i++) sv_q.push_back(rf_val(AW'(i)));
  endtask

  task automatic restore_run(input int last, input bit gaps);
    for (int k = 1; k <= last; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = DW'(32'hA000 + k);
      rs_q.push_back({AW'(k), DW'(32'hA000 + k)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    logic [3:0] pat;
    pat = 4'b1001;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0;
    out_ready = 1'b1; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    hs_cnt = 0; first_hs = 0; last_hs = 0; done_cnt = 0; stall_prev = 1'b0; stall_data = '0;

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dut0", {busy0, done0, ov0, we0, ir0, od0}, '0);
    chk("rst_dut1", {busy1, done1, ov1, we1, ir1, od1}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate save, no FP bank
    sel = 1'b0; hs_cnt = 0; base = done_cnt;
    push_save(31);
    pulse_start(1'b0);
    chk("busy_save", 64'(busy), 64'd1);
    wait_done(base, 200);
    @(negedge clk);
    chk("done_width", {done, busy}, 2'b00);
    chk("save_count", 64'(hs_cnt), 64'd31);
    chk("save_rate", 64'(last_hs - first_hs), 64'd30);
    chk("save_sb_empty", 64'(sv_q.size()), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("save_done_once", 64'(done_cnt - base), 64'd1);

    // Stalled save with FP bank; stray start/dir mid-operation
    sel = 1'b1; hs_cnt = 0; base = done_cnt;
    push_save(63);
    pulse_start(1'b0);
    for (int n = 0; n < 600 && done_cnt == base; n++) begin
      out_ready = pat[cyc % 4];
      start     = (n == 7);
      dir       = (n >= 7 && n < 20);
      @(posedge clk); #1;
    end
    start = 1'b0; dir = 1'b0; out_ready = 1'b1;
    if (done_cnt == base) chk("stall_timeout", 64'd0, 64'd1);
    chk("stall_count", 64'(hs_cnt), 64'd63);
    chk("stall_sb_empty", 64'(sv_q.size()), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("stall_idle", {busy1, busy0, ov1}, 3'b000);

    // Gapped restore with FP bank
    sel = 1'b1; base = done_cnt;
    pulse_start(1'b1);
    chk("in_ready_rst", 64'(in_ready), 64'd1);
    restore_run(63, 1'b1);
    wait_done(base, 20);
    @(negedge clk);
    chk("restore_after", {in_ready, rf_we, busy}, 3'b000);
    chk("restore_sb_empty", 64'(rs_q.size()), 64'd0);

    // Abort after word 10 of a save, then a clean save
    sel = 1'b0; hs_cnt = 0; base = done_cnt;
    push_save(31);
    pulse_start(1'b0);
    for (int n = 0; n < 100 && hs_cnt < 10; n++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {ov, busy, od}, '0);
    sv_q.delete();
    repeat (4) @(posedge clk); #1;
    chk("abort_no_done", 64'(done_cnt - base), 64'd0);
    push_save(31);
    pulse_start(1'b0);
    wait_done(base, 200);
    chk("resave_sb_empty", 64'(sv_q.size()), 64'd0);

    // Asynchronous reset mid-restore at idx=5, then a clean restore
    sel = 1'b1; base = done_cnt;
    pulse_start(1'b1);
    restore_run(4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, done, ov, rf_we, in_ready, od}, '0);
    chk("rst_sb_empty", 64'(rs_q.size()), 64'd0);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_done", 64'(done_cnt - base), 64'd0);
    pulse_start(1'b1);
    restore_run(63, 1'b0);
    wait_done(base, 20);
    chk("rerestore_sb_empty", 64'(rs_q.size()), 64'd0);
    repeat (2) @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
